// File: rtl/pic_int_sequencer.sv
// 8259A-style priority resolver and 8086 INTA sequencer: latches IR requests,
// arbitrates against IMR/ISR with rotating priority and drives the vector byte.
module pic_int_sequencer #(
  parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       icw1_init,
  input  logic       ltim,
  input  logic       aeoi,
  input  logic [4:0] vec_base,
  input  logic [7:0] imr,
  input  logic [7:0] ir,
  input  logic       inta_n,
  input  logic       ocw2_valid,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  output logic       int_req,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] vec_out,
  output logic       vec_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK1,
    S_ACK2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ir_q;
  logic       inta_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lp_q, lp_d;
  logic       rot_q, rot_d;
  logic       int_q, int_d;
  logic [7:0] vec_q, vec_d;
  logic       oe_q, oe_d;
  logic [2:0] ack_lvl_q, ack_lvl_d;
  logic       ack_vld_q, ack_vld_d;

  logic       fall;
  logic       cand_vld, isr_vld, int_next;
  logic [2:0] cand_lvl, isr_top, cand_rank, isr_rank;
  logic [7:0] isr_set, isr_clr, irr_clr, irr_new;

  // Scan lp+1, lp+2, ... mod 8; returns {found, level} of the first set bit.
  function automatic logic [3:0] pri_pick(input logic [7:0] v, input logic [2:0] lp);
    logic       found;
    logic [2:0] lvl;
    logic [2:0] idx;
    found = 1'b0;
    lvl   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = lp + 3'(k + 1);
      if (!found && v[idx]) begin
        found = 1'b1;
        lvl   = idx;
      end
    end
    return {found, lvl};
  endfunction

  assign fall = ~inta_n & inta_q;

  always_comb begin
    {cand_vld, cand_lvl} = pri_pick(irr_q & ~imr, lp_q);
    {isr_vld, isr_top}   = pri_pick(isr_q, lp_q);
    cand_rank = cand_lvl - lp_q - 3'd1;
    isr_rank  = isr_top - lp_q - 3'd1;
    int_next  = cand_vld & (~isr_vld | (cand_rank < isr_rank));
  end

  always_comb begin
    state_d   = state_q;
    int_d     = 1'b0;
    vec_d     = vec_q;
    oe_d      = oe_q;
    ack_lvl_d = ack_lvl_q;
    ack_vld_d = ack_vld_q;
    lp_d      = lp_q;
    rot_d     = rot_q;
    isr_set   = '0;
    isr_clr   = '0;
    irr_clr   = '0;

    unique case (state_q)
      S_IDLE, S_REQ: begin
        if (fall) begin
          state_d   = S_ACK1;
          ack_vld_d = cand_vld;
          ack_lvl_d = cand_vld ? cand_lvl : SPURIOUS_IR;
          if (cand_vld) begin
            isr_set[cand_lvl] = 1'b1;
            irr_clr[cand_lvl] = 1'b1;
          end
        end else begin
          int_d   = int_next;
          state_d = int_q ? S_REQ : S_IDLE;
        end
      end
      S_ACK1: begin
        if (fall) begin
          state_d = S_ACK2;
          vec_d   = {vec_base, ack_lvl_q};
          oe_d    = 1'b1;
        end
      end
      S_ACK2: begin
        oe_d = ~inta_n;
        if (inta_n) begin
          state_d = S_IDLE;
          if (aeoi && ack_vld_q) begin
            isr_clr[ack_lvl_q] = 1'b1;
            if (rot_q) lp_d = ack_lvl_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ocw2_valid) begin
      unique case (ocw2_cmd)
        3'b001: if (isr_vld) isr_clr[isr_top] = 1'b1;
        3'b011: isr_clr[ocw2_level] = 1'b1;
        3'b101: begin
          if (isr_vld) begin
            isr_clr[isr_top] = 1'b1;
            lp_d             = isr_top;
          end
        end
        3'b111: begin
          isr_clr[ocw2_level] = 1'b1;
          lp_d                = ocw2_level;
        end
        3'b110: lp_d  = ocw2_level;
        3'b100: rot_d = 1'b1;
        3'b000: rot_d = 1'b0;
        default: ;
      endcase
    end

    // Set after clear so an acknowledge wins over a same-cycle EOI on that bit.
    isr_d   = (isr_q & ~isr_clr) | isr_set;
    irr_new = ltim ? ir : (ir & (irr_q | ~ir_q));
    irr_d   = irr_new & ~irr_clr;
  end

  // Plain history flop: always holds the previous ir, so reset/ICW1 see it loaded.
  always_ff @(posedge clk) begin
    ir_q <= ir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b1;
      irr_q     <= '0;
      isr_q     <= '0;
      lp_q      <= 3'd7;
      rot_q     <= 1'b0;
      int_q     <= 1'b0;
      vec_q     <= '0;
      oe_q      <= 1'b0;
      ack_lvl_q <= '0;
      ack_vld_q <= 1'b0;
    end else if (icw1_init) begin
      state_q   <= S_IDLE;
      inta_q    <= inta_n;
      irr_q     <= '0;
      isr_q     <= '0;
      lp_q      <= 3'd7;
      rot_q     <= 1'b0;
      int_q     <= 1'b0;
      vec_q     <= '0;
      oe_q      <= 1'b0;
      ack_lvl_q <= '0;
      ack_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_n;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      lp_q      <= lp_d;
      rot_q     <= rot_d;
      int_q     <= int_d;
      vec_q     <= vec_d;
      oe_q      <= oe_d;
      ack_lvl_q <= ack_lvl_d;
      ack_vld_q <= ack_vld_d;
    end
  end

  assign int_req = int_q;
  assign irr     = irr_q;
  assign isr     = isr_q;
  assign vec_out = vec_q;
  assign vec_oe  = oe_q;

endmodule
